fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Fetch sequencer between the program counter and the instruction memory.
- Owns the PC and issues one instruction-memory request at a time over a req/gnt + rsp handshake.
- Delivers fetched instructions to decode through a valid/ready output register.
- Handles branch/jump redirects, including discarding a response already in flight. Replaces the free-running PC+4 counter in the fetch stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when the output register is empty or reset.

Ports:
- clk  input  1  Clock; all state updates on posedge.
- reset  input  1  Synchronous, active-low reset: sampled on posedge clk, reset==0 resets the block.
- imem_req  output  1  Request valid to instruction memory.
- imem_addr  output  32  Request address, word aligned.
- imem_gnt  input  1  Memory accepts the request this cycle (req&gnt = issue).
- imem_rsp_valid  input  1  Response data valid; exactly one response per issued request, at least 1 cycle after issue.
- imem_rsp_data  input  32  Instruction word.
- if_valid  output  1  Output register holds an instruction.
- if_instr  output  32  Instruction to decode.
- if_pc  output  32  PC of if_instr.
- id_ready  input  1  Decode accepts; transfer = if_valid & id_ready.
- redir_valid  input  1  Redirect pulse from execute.
- redir_pc  input  32  Redirect target.
- misalign_err  output  1  One-cycle pulse: redir_pc[1:0] != 0.
- fetch_cnt  output  32  Count of completed decode transfers.

Behaviour:
- State values: IDLE, REQ, WAIT, KILL. Internal pc register.
- On reset==0:
  - pc = RESET_PC; state = IDLE.
  - if_valid = 0, if_instr = NOP_INSTR, if_pc = 0.
  - imem_req = 0, misalign_err = 0, fetch_cnt = 0.
- Reset mid-operation:
  - Abandons any in-flight request.
  - A response arriving after reset release while in IDLE/REQ is ignored.
- IDLE: one cycle after reset release, go to REQ. imem_req = 0.
- REQ:
  - imem_addr = pc.
  - imem_req = 1 only when the slot is free: if_valid==0, or (if_valid & id_ready) this cycle.
  - imem_addr and imem_req stay stable until gnt, except on redirect.
  - On req&gnt: go to WAIT.
- WAIT: on imem_rsp_valid:
  - if_instr = rsp_data, if_pc = pc, if_valid = 1.
  - pc = pc+4.
  - Go to REQ.
  - The slot is guaranteed empty here because issue required it.
- Output register:
  - Transfer clears if_valid, unless refilled the same cycle.
  - if_instr returns to NOP_INSTR when the slot is empty.
  - Minimum fetch latency is issue+1 cycle, giving throughput of 1 instruction per 2 cycles with 1-cycle memory.
- KILL:
  - Waits for the in-flight response and discards it (no output, pc unchanged).
  - Then go to REQ.
  - imem_req = 0.
- Redirect (redir_valid==1) has highest priority over all other events:
  - pc = {redir_pc[31:2],2'b00}.
  - if_valid = 0 (flush); a transfer in the same cycle is void and fetch_cnt does not increment.
  - misalign_err = 1 for that cycle if redir_pc[1:0] != 0.
  - Next state depends on current state and memory activity:
    - IDLE -> REQ.
    - REQ without gnt -> REQ; the address changes to the new pc next cycle.
    - REQ with gnt the same cycle -> KILL.
    - WAIT without rsp_valid -> KILL.
    - WAIT with rsp_valid the same cycle -> response discarded, go to REQ.
    - KILL without rsp_valid -> KILL.
    - KILL with rsp_valid -> REQ.
- Arithmetic:
  - pc+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
  - fetch_cnt increments by 1 per valid transfer and wraps at 2^32.
- Redirect while reset==0: reset wins.
- Only one request is outstanding at a time, ever.

Test Plan:
- Reset then 1-cycle-latency memory returning addr as data, id_ready=1 -> imem_addr sequence 0,4,8,12; if_pc/if_instr 0,4,8 each valid one cycle; fetch_cnt=3 after the third transfer.
- id_ready=0 for 5 cycles with if_valid=1 -> if_instr/if_pc hold; imem_req=0 throughout; when id_ready=1, the next req is issued in that same cycle.
- Redirect to 0x100 in the cycle req&gnt for 0x8 -> state KILL; the response for 0x8 is dropped; next imem_addr=0x100; if_pc=0x100 delivered; no instruction with if_pc=0x8 is delivered.
- Redirect to 0x203 while REQ without gnt -> misalign_err pulses 1 cycle; imem_addr=0x200 next cycle; if_valid cleared.
- Redirect while if_valid=1 and id_ready=1 -> if_valid=0 next cycle; fetch_cnt unchanged.
- Redirect to 0xFFFF_FFFC, then two fetches -> if_pc 0xFFFF_FFFC then 0x0000_0000.
- reset=0 asserted during WAIT -> all outputs at reset values next cycle; a late rsp_valid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instruction-memory request at a time
// and hands fetched instructions to decode through a valid/ready output register.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        issue;
  logic        xfer;

  always_comb begin
    imem_addr    = pc;
    // A request is only raised when the output slot will be free to take its response.
    imem_req     = reset && (state == REQ) && (!if_valid || id_ready);
    issue        = imem_req && imem_gnt;
    xfer         = if_valid && id_ready && !redir_valid;
    misalign_err = reset && redir_valid && (redir_pc[1:0] != 2'b00);

    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (redir_valid)  state_nxt = issue ? KILL : REQ;
        else if (issue)   state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid)   state_nxt = REQ;
        else if (redir_valid) state_nxt = KILL;
      end
      KILL: begin
        if (imem_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= NOP_INSTR;
      if_pc     <= '0;
      fetch_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) fetch_cnt <= fetch_cnt + 32'd1;
      // Redirect flushes the slot and also drops a response landing this cycle.
      if (redir_valid) begin
        pc       <= {redir_pc[31:2], 2'b00};
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end else if (state == WAIT && imem_rsp_valid) begin
        if_valid <= 1'b1;
        if_instr <= imem_rsp_data;
        if_pc    <= pc;
        pc       <= pc + 32'd4;
      end else if (xfer) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end
  end

endmodule
